main_fsm: RTL
=============

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous and active-low; deasserted synchronously to clk by the system.
REQ-003 op  in  7  opcode from instruction register, stable from DECODE onward.
REQ-004 PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc  out  1 each  datapath enables/selects.
REQ-005 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  datapath mux selects; ALUOp drives the ALU decoder.
REQ-006 illegal  out  1  high for the single DECODE cycle of an unsupported opcode.
REQ-007 state  out  4  current state encoding, for debug/verification.

Function
REQ-008 Moore FSM with registered state; all outputs except illegal decode combinationally from state only.
REQ-009 Encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 unused.
REQ-010 Supported op: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-011 Transitions: FETCH->DECODE; MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BEQ ->FETCH; EXECUTER, EXECUTEI, JAL ->ALUWB.
REQ-012 DECODE: lw/sw->MEMADR, R->EXECUTER, I-ALU->EXECUTEI, jal->JAL, beq->BEQ, any other op->FETCH with illegal=1.
REQ-013 MEMADR: lw->MEMREAD, sw->MEMWRITE; any other op (op changed illegally) ->FETCH.
REQ-014 Unused state codes SHALL transition to FETCH next cycle with all outputs at default.
REQ-015 Defaults in every state unless listed: all 1-bit outputs 0, all 2-bit outputs 00.
REQ-016 FETCH: IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch-target precompute).
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; ALUWB: ResultSrc=00, RegWrite=1.
REQ-021 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-023 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-024 Cycles per instruction: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, illegal 2.
REQ-025 ALUOp SHALL never be 11 in any state.
REQ-026 Exactly one of {RegWrite, MemWrite} or neither in any cycle; never both.

Reset
REQ-027 reset_n low SHALL force state to FETCH immediately, without waiting for clk.
REQ-028 While reset_n low, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, illegal SHALL be 0; mux selects take FETCH values.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further write enable; first rising edge after deassertion executes FETCH with IRWrite=1, PCUpdate=1.

Verification
REQ-030 Reset release, op=0000011 held -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01.
REQ-031 op=0100011 -> states 0,1,2,5,0; MemWrite=1 in state 5 only, AdrSrc=1; RegWrite never 1.
REQ-032 op=0110011 then 0010011 -> 0,1,6,7,0 then 0,1,8,7,0; ALUOp=10 in states 6/8; ALUSrcB 00 vs 01.
REQ-033 op=1100011 -> 0,1,10,0 with Branch=1, ALUOp=01 in state 10; op=1101111 -> 0,1,9,7,0 with PCUpdate=1 in 9.
REQ-034 op=0000000 -> 0,1,0; illegal=1 for exactly the DECODE cycle; no write enable except FETCH's.
REQ-035 reset_n pulsed low asynchronously during MEMWRITE -> MemWrite drops to 0 within the same cycle, state=0; force state=13 -> next state 0.

Source files
------------

// File: rtl/main_fsm_if.sv
// -----------------------------------------------------------------------------
// main_fsm_if
// Groups the opcode input and all control outputs of the multicycle main
// control FSM.
//   op        : 7-bit opcode from the instruction register (datapath -> FSM)
//   PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc : 1-bit enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp : 2-bit mux selects (FSM -> datapath)
//   illegal   : unsupported opcode seen in DECODE
//   state     : current state encoding, for debug
// Modports:
//   master : datapath side (drives op, observes controls)
//   slave  : FSM side (observes op, drives controls)
// -----------------------------------------------------------------------------
interface main_fsm_if;
   logic [6:0] op;
   logic       PCUpdate;
   logic       Branch;
   logic       RegWrite;
   logic       MemWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       illegal;
   logic [3:0] state;

   modport master (
      output op,
      input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, state
   );

   modport slave (
      input  op,
      output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, state
   );
endinterface

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
// Main control FSM of a multicycle RISC-V style processor (lw, sw, R-type,
// I-ALU, beq, jal). Moore machine: every control output is decoded from the
// registered state only; "illegal" additionally looks at op during DECODE.
// Ports:
//   clk     : clock, state advances on the rising edge
//   reset_n : asynchronous active-low reset, forces FETCH immediately
//   bus     : main_fsm_if.slave (op in; control outputs, illegal, state out)
// -----------------------------------------------------------------------------
module main_fsm (
   input  logic       clk,
   input  logic       reset_n,
   main_fsm_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTER = 4'd6,
      ST_ALUWB    = 4'd7,
      ST_EXECUTEI = 4'd8,
      ST_JAL      = 4'd9,
      ST_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // Held as plain 4 bits so the unused codes 11..15 are representable and
   // recover through the default branch below.
   logic [3:0] r_state;
   state_t     w_next;

   logic       w_pcupdate;
   logic       w_branch;
   logic       w_regwrite;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_adrsrc;
   logic [1:0] w_resultsrc;
   logic [1:0] w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_aluop;
   logic       w_illegal;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_FETCH;
      else          r_state <= w_next;
   end

   // Next state and Moore outputs
   always_comb begin
      w_next      = ST_FETCH;
      w_pcupdate  = 1'b0;
      w_branch    = 1'b0;
      w_regwrite  = 1'b0;
      w_memwrite  = 1'b0;
      w_irwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_resultsrc = 2'b00;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      w_aluop     = 2'b00;
      w_illegal   = 1'b0;

      case (r_state)
         ST_FETCH: begin
            w_next      = ST_DECODE;
            w_irwrite   = 1'b1;
            w_pcupdate  = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
         end
         ST_DECODE: begin
            // ALU precomputes the branch target PC + imm while op is decoded
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: w_next = ST_MEMADR;
               OP_R:         w_next = ST_EXECUTER;
               OP_I:         w_next = ST_EXECUTEI;
               OP_JAL:       w_next = ST_JAL;
               OP_BEQ:       w_next = ST_BEQ;
               default: begin
                  w_next    = ST_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            // op should still be lw/sw; anything else abandons the access
            if (bus.op == OP_LW)      w_next = ST_MEMREAD;
            else if (bus.op == OP_SW) w_next = ST_MEMWRITE;
            else                      w_next = ST_FETCH;
         end
         ST_MEMREAD: begin
            w_next   = ST_MEMWB;
            w_adrsrc = 1'b1;
         end
         ST_MEMWB: begin
            w_next      = ST_FETCH;
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
         end
         ST_MEMWRITE: begin
            w_next     = ST_FETCH;
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         ST_EXECUTER: begin
            w_next    = ST_ALUWB;
            w_alusrca = 2'b10;
            w_aluop   = 2'b10;
         end
         ST_ALUWB: begin
            w_next     = ST_FETCH;
            w_regwrite = 1'b1;
         end
         ST_EXECUTEI: begin
            w_next    = ST_ALUWB;
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_aluop   = 2'b10;
         end
         ST_JAL: begin
            // PC <= target precomputed in DECODE; ALU forms PC+4 for rd
            w_next     = ST_ALUWB;
            w_alusrca  = 2'b01;
            w_alusrcb  = 2'b10;
            w_pcupdate = 1'b1;
         end
         ST_BEQ: begin
            w_next    = ST_FETCH;
            w_alusrca = 2'b10;
            w_aluop   = 2'b01;
            w_branch  = 1'b1;
         end
         default: begin
            w_next = ST_FETCH;
         end
      endcase
   end

   // The state register already sits in FETCH while reset is low; gating
   // the enables keeps FETCH's IRWrite/PCUpdate from firing during reset.
   assign bus.PCUpdate  = w_pcupdate & reset_n;
   assign bus.Branch    = w_branch   & reset_n;
   assign bus.RegWrite  = w_regwrite & reset_n;
   assign bus.MemWrite  = w_memwrite & reset_n;
   assign bus.IRWrite   = w_irwrite  & reset_n;
   assign bus.illegal   = w_illegal  & reset_n;
   assign bus.AdrSrc    = w_adrsrc;
   assign bus.ResultSrc = w_resultsrc;
   assign bus.ALUSrcA   = w_alusrca;
   assign bus.ALUSrcB   = w_alusrcb;
   assign bus.ALUOp     = w_aluop;
   assign bus.state     = r_state;

endmodule
